jk_access_sequencer: RTL and testbench
======================================

// Module: jk_access_sequencer
// PURPOSE
//  Shares one external JK flip-flop among N_REQ requesters.
//  Each requester issues a 2-bit op (HOLD/RESET/SET/TOGGLE). A round-robin arbiter picks one.
//  The block drives j/k to the flop for exactly one clock, then reads back q and checks it against the expected value.
//  It reports done, the resulting q and a mismatch error. Sits between requester logic and the jk flop instance.
// PARAMETERS
//  N_REQ  2  number of requesters; legal range 1..8
// PORTS
//  clk    in   1          single clock; all state updates on posedge
//  reset  in   1          asynchronous, active-high
//  req    in   N_REQ      per-requester request; hold until done
//  op     in   2*N_REQ    op[2i+1:2i] for requester i; hold until done
//  gnt    out  N_REQ      one-hot grant, registered
//  done   out  1          one-cycle completion pulse
//  q_out  out  1          flop q sampled in CHECK; valid while done=1
//  err    out  1          q_out != expected; valid while done=1
//  jk_j   out  1          to flop j input
//  jk_k   out  1          to flop k input
//  jk_q   in   1          from flop q output
// BEHAVIOUR
//  Op encoding: 00 HOLD (j0 k0, exp=q), 01 RESET (j0 k1, exp=0), 10 SET (j1 k0, exp=1), 11 TOGGLE (j1 k1, exp=~q).
//  Reset (async, any state): state=IDLE; gnt, jk_j, jk_k, done, q_out, err = 0; rr_ptr=0.
//   An in-flight op is abandoned with no done pulse.
//  FSM IDLE -> DRIVE -> CHECK -> DONE -> IDLE; each non-IDLE state lasts exactly 1 cycle.
//  IDLE: if |req, the winner is the first set req at index >= rr_ptr, wrapping modulo N_REQ.
//   On the next edge: gnt=onehot(winner); latch op[winner]; exp computed from current jk_q; rr_ptr=(winner+1)%N_REQ; go DRIVE.
//   If req==0, stay IDLE with all outputs 0.
//  DRIVE: jk_j/jk_k = decoded latched op (registered); the flop captures at the edge ending DRIVE.
//  CHECK: jk_j=jk_k=0. On the edge ending CHECK: q_out<=jk_q, err<=(jk_q!=exp), done<=1.
//  DONE: done=1, gnt still held; no arbitration in this cycle. On the edge ending DONE: done, gnt, err -> 0; go IDLE.
//  Latency: req seen in IDLE at edge n -> gnt from edge n+1, done high between edges n+3 and n+4. Throughput: 1 op per 4 cycles.
//  jk_j and jk_k are 0 in every state except DRIVE. The flop is never driven while idle.
//  Requester drops req mid-op: the op still completes and done pulses. Op changes after grant are ignored (latched value used).
//  Requester still asserting req in IDLE after its DONE is re-arbitrated normally. The advanced rr_ptr prevents starvation.
//  N_REQ=1: arbiter degenerates; rr_ptr stays 0.
//  exp for HOLD/TOGGLE is derived from jk_q sampled at the grant edge. Any external q disturbance before CHECK shows as err.
// STRUCTURE
//  Package jk_seq_pkg: op encodings (OP_HOLD/OP_RESET/OP_SET/OP_TOGGLE); state encoding (IDLE/DRIVE/CHECK/DONE, 2 bits);
//   function op_to_jk(op) -> {j,k}.
//  Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot gnt and winner index; combinational.
//   The sequencer registers its result.
//  Top: FSM, op/exp latch, registered jk and status outputs.
// TESTING
//  1. Reset mid-op: assert reset during DRIVE -> jk_j=jk_k=0, gnt=0, done never pulses; next req is served from rr_ptr=0.
//  2. Single req0 op=SET with q=0 -> gnt=01 for 3 cycles; j=1 k=0 for exactly 1 cycle; done=1, q_out=1, err=0; edge-count latency exactly 3.
//  3. req0 op=TOGGLE issued 3 times back-to-back, q initially 0 -> q_out sequence 1,0,1; err=0; 4 cycles per op.
//  4. req=11 held continuously, op0=SET, op1=RESET -> grants alternate 01,10,01,10; q_out alternates 1,0,...
//  5. HOLD with q=1, then RESET -> q_out=1 then 0; jk_j=jk_k=0 throughout the HOLD op; err=0.
//  6. Fault: bench model forces jk_q=0 during a SET -> done=1, q_out=0, err=1 for one cycle; next op has err=0.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings and decode helpers for the JK flop access sequencer.
package jk_seq_pkg;

    // Requester operation codes; the two bits map directly onto {j,k}.
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    // Sequencer states; every state other than IDLE lasts one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    localparam int unsigned OP_W = 2;

    // Decode an op into the {j,k} pair applied to the flop.
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (jk_op_e'(op))
            OP_HOLD:   jk = 2'b00;
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

    // Value the flop should hold after the op, given q before it.
    function automatic logic op_expected(input logic [1:0] op, input logic q);
        logic e;
        case (jk_op_e'(op))
            OP_HOLD:   e = q;
            OP_RESET:  e = 1'b0;
            OP_SET:    e = 1'b1;
            OP_TOGGLE: e = ~q;
            default:   e = q;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    int unsigned      idx;
    logic [PTR_W-1:0] idx_w;

    // Scan from ptr upward modulo N and keep the first hit.
    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx   = (32'(ptr) + i) % N;
            idx_w = PTR_W'(idx);
            if (!valid && req[idx_w]) begin
                valid       = 1'b1;
                gnt[idx_w]  = 1'b1;
                winner      = idx_w;
            end
        end
    end

endmodule

// File: rtl/jk_access_sequencer.sv
// Shares one external JK flop among N_REQ requesters: arbitrate, drive j/k
// for one cycle, read q back and report it with a mismatch flag.
module jk_access_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    op,
    output logic [N_REQ-1:0]      gnt,
    output logic                  done,
    output logic                  q_out,
    output logic                  err,
    output logic                  jk_j,
    output logic                  jk_k,
    input  logic                  jk_q
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    seq_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               exp_q, exp_d;
    logic               jk_j_q, jk_j_d;
    logic               jk_k_q, jk_k_d;
    logic               done_q, done_d;
    logic               q_out_q, q_out_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   arb_winner;
    logic               arb_valid;
    logic [OP_W-1:0]    sel_op;
    logic [1:0]         sel_jk;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Pick the winner's op with a one-hot mux, avoiding a variable part-select.
    always_comb begin
        sel_op = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op = op[2*i +: 2];
            end
        end
        sel_jk = op_to_jk(sel_op);
    end

    // Next-state and registered-output logic for the access sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        exp_d   = exp_q;
        jk_j_d  = 1'b0;
        jk_k_d  = 1'b0;
        done_d  = 1'b0;
        q_out_d = q_out_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d   = '0;
                q_out_d = 1'b0;
                err_d   = 1'b0;
                if (arb_valid) begin
                    gnt_d  = arb_gnt;
                    jk_j_d = sel_jk[1];
                    jk_k_d = sel_jk[0];
                    exp_d  = op_expected(sel_op, jk_q);
                    if (32'(arb_winner) == N_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_winner + PTR_W'(1);
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                q_out_d = jk_q;
                err_d   = (jk_q != exp_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                q_out_d = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            exp_q   <= 1'b0;
            jk_j_q  <= 1'b0;
            jk_k_q  <= 1'b0;
            done_q  <= 1'b0;
            q_out_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            exp_q   <= exp_d;
            jk_j_q  <= jk_j_d;
            jk_k_q  <= jk_k_d;
            done_q  <= done_d;
            q_out_q <= q_out_d;
            err_q   <= err_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign q_out = q_out_q;
    assign err   = err_q;
    assign jk_j  = jk_j_q;
    assign jk_k  = jk_k_q;

endmodule

// File: tb/tb_jk_access_sequencer.sv
// Directed bench for jk_access_sequencer with a behavioural external JK flop.
module tb_jk_access_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] op;
    logic [1:0] gnt;
    logic       done, q_out, err, jk_j, jk_k, jk_q;

    logic       fq = 1'b0;
    logic       fault = 1'b0;

    int nchk = 0;
    int nerr = 0;

    jk_access_sequencer #(.N_REQ(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op    (op),
        .gnt   (gnt),
        .done  (done),
        .q_out (q_out),
        .err   (err),
        .jk_j  (jk_j),
        .jk_k  (jk_k),
        .jk_q  (jk_q)
    );

    always #5 clk = ~clk;

    // External JK flop; fault forces the read-back value low.
    always @(posedge clk) begin
        case ({jk_j, jk_k})
            2'b01:   fq <= 1'b0;
            2'b10:   fq <= 1'b1;
            2'b11:   fq <= ~fq;
            default: fq <= fq;
        endcase
    end
    assign jk_q = fault ? 1'b0 : fq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One complete op starting at a negedge in IDLE; ends at the negedge back in IDLE.
    task automatic op_cycle(input logic [1:0] rq, input logic [3:0] ov, input logic [1:0] eg,
                            input logic ej, input logic ek, input logic eq, input logic ee,
                            input bit hold, input string tag);
        req = rq;
        op  = ov;
        @(negedge clk);
        chk({tag, ".drv.gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".drv.j"}, 32'(jk_j), 32'(ej));
        chk({tag, ".drv.k"}, 32'(jk_k), 32'(ek));
        chk({tag, ".drv.done"}, 32'(done), 0);
        @(negedge clk);
        chk({tag, ".chk.gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".chk.jk"}, 32'({jk_j, jk_k}), 0);
        chk({tag, ".chk.done"}, 32'(done), 0);
        @(negedge clk);
        chk({tag, ".dn.done"}, 32'(done), 1);
        chk({tag, ".dn.q"}, 32'(q_out), 32'(eq));
        chk({tag, ".dn.err"}, 32'(err), 32'(ee));
        chk({tag, ".dn.gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".dn.jk"}, 32'({jk_j, jk_k}), 0);
        if (!hold) req = '0;
        @(negedge clk);
        chk({tag, ".idle.done"}, 32'(done), 0);
        chk({tag, ".idle.gnt"}, 32'(gnt), 0);
        chk({tag, ".idle.err"}, 32'(err), 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        op    = '0;
        @(negedge clk);
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.jk", 32'({jk_j, jk_k}), 0);
        chk("rst.qerr", 32'({q_out, err}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.noreq.gnt", 32'(gnt), 0);

        // Single SET on req0 with q=0; done on the third edge after req.
        op_cycle(2'b01, 4'b00_10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "set0");

        // Reset during DRIVE of a RESET op on req0 (rr_ptr was 1).
        req = 2'b01;
        op  = 4'b00_01;
        @(negedge clk);
        chk("rmid.drv.gnt", 32'(gnt), 32'h1);
        chk("rmid.drv.k", 32'(jk_k), 1);
        #2 reset = 1'b1;
        #1;
        chk("rmid.async.jk", 32'({jk_j, jk_k}), 0);
        chk("rmid.async.gnt", 32'(gnt), 0);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rmid.nodone", 32'(done), 0);
        end
        chk("rmid.qheld", 32'(fq), 1);
        // Both request; rr_ptr back at 0 so req0 (RESET) wins over req1 (HOLD).
        op_cycle(2'b11, 4'b00_01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rmid.next");

        // Three back-to-back TOGGLEs on req0 from q=0.
        op_cycle(2'b01, 4'b00_11, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "tog1");
        op_cycle(2'b01, 4'b00_11, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "tog2");
        op_cycle(2'b01, 4'b00_11, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "tog3");

        // HOLD with q=1, then RESET.
        op_cycle(2'b01, 4'b00_00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "hold");
        op_cycle(2'b01, 4'b00_01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst0");

        // Return rr_ptr to 0, then both requesters held: grants alternate.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                op_cycle(2'b11, 4'b01_10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, k != 3, "alt.r0");
            else
                op_cycle(2'b11, 4'b01_10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, k != 3, "alt.r1");
        end

        // Read-back forced low during a SET: err for one cycle, next op clean.
        fault = 1'b1;
        op_cycle(2'b01, 4'b00_10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "fault");
        fault = 1'b0;
        op_cycle(2'b01, 4'b00_01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "postfault");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
